cpu_debug_vjtag_host: RTL and testbench
=======================================

CPU_DEBUG_VJTAG_HOST -- requirements
Module: cpu_debug_vjtag_host

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2: clk cycles per TCK half-period, legal range >=1.
REQ-002 SHALL have parameter DR_LEN, default 38: DR scan length in bits.
REQ-003 SHALL have parameter RTI_TCKS, default 1: number of TCK periods spent in run-test-idle after each scan, legal range >=1.
REQ-004 SHALL have ports clk in 1 (sole clock) and reset in 1 (synchronous, active-high); one clock, no other clock domains.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_ir in 2, cmd_dr in DR_LEN and cmd_ir_only in 1 (skip the DR scan).
REQ-006 SHALL have ports resp_valid out 1, resp_ready in 1, resp_data out DR_LEN (captured TDO) and resp_ir_out out 2.
REQ-007 SHALL have ports vji_tck out 1, vji_tdi out 1, vji_tdo in 1, vji_ir_in out 2 and vji_ir_out in 2.
REQ-008 SHALL have strobe output ports vji_uir, vji_cdr, vji_sdr, vji_udr and vji_rti, each out 1.

Function
REQ-009 SHALL be the host/driver end of the debug-slave virtual-JTAG link, sequencing IR and DR scans into the slave's tck-domain logic.
REQ-010 TCK timing SHALL be:
- vji_tck held low in IDLE;
- otherwise vji_tck toggles every TCK_DIV clk cycles;
- each TCK period starts low and lasts 2*TCK_DIV clk cycles.
REQ-011 All driven vji_* signals (tdi, strobes, ir_in) SHALL change only on the clk cycle vji_tck falls, or on IDLE exit with vji_tck low.
REQ-012 vji_tdo and vji_ir_out SHALL be sampled on the clk cycle vji_tck rises.
REQ-013 The FSM SHALL have states IDLE, UIR, CDR, SDR, UDR, RTI and RESP.
REQ-014 A command SHALL be accepted when cmd_valid && cmd_ready; cmd_ready=1 only in IDLE.
REQ-015 On acceptance, the FSM SHALL:
- latch cmd_ir, cmd_dr and cmd_ir_only;
- drive vji_ir_in=cmd_ir, held until the next acceptance;
- enter UIR.
REQ-016 UIR SHALL last 1 TCK period with vji_uir=1; vji_ir_out is captured into resp_ir_out at its rising edge.
REQ-017 After UIR, the FSM SHALL go to RTI if cmd_ir_only=1, else CDR.
REQ-018 CDR SHALL last 1 TCK period with vji_cdr=1.
REQ-019 SDR SHALL last exactly DR_LEN TCK periods with vji_sdr=1, and SHALL shift as follows:
- vji_tdi = cmd_dr bit k in period k, LSB first;
- TDO captured at each rising edge into resp_data bit k.
REQ-020 UDR SHALL last 1 TCK period with vji_udr=1.
REQ-021 RTI SHALL last RTI_TCKS TCK periods with vji_rti=1.
REQ-022 At the end of the final RTI period (vji_tck falling), the FSM SHALL go to RESP with vji_tck low.
REQ-023 In RESP: resp_valid=1 and resp_data/resp_ir_out stable; on resp_ready the FSM goes to IDLE, with cmd_ready=1 on the next cycle.
REQ-024 resp_data SHALL be all zero for cmd_ir_only commands.
REQ-025 Exactly one of vji_uir/cdr/sdr/udr/rti SHALL be high outside IDLE/RESP; all SHALL be low in IDLE/RESP.
REQ-026 Latency from acceptance to resp_valid SHALL be (DR_LEN+3+RTI_TCKS)*2*TCK_DIV clk cycles for a full scan, and (1+RTI_TCKS)*2*TCK_DIV for ir_only.
REQ-027 vji_tdi SHALL be 0 outside SDR.
REQ-028 cmd inputs SHALL be ignored outside IDLE; the latched copy SHALL be used for the whole scan.

Reset
REQ-029 While reset=1 at a clk edge, the block SHALL return to IDLE and all outputs SHALL be 0 except cmd_ready=1 from the cycle after reset deasserts.
REQ-030 Reset mid-scan SHALL abort the scan: vji_tck low and strobes low on the next cycle, the partial response discarded, no resp_valid.
REQ-031 The TCK half-period counter and bit counter SHALL clear on reset.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the VJI_IR_W=2 constant and the default DR_LEN=38.
REQ-033 One sub-module, cpu_debug_vjtag_host_tckgen, SHALL hold the TCK half-period counter and provide tck, rise_pulse and fall_pulse, gated by a run input.
REQ-034 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-035 Full scan with defaults: cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A, slave model TDO preloaded 38'h12_3456_789A -> model receives 38'h2A_5A5A_5A5A; resp_data=38'h12_3456_789A; 42 TCK rises; resp_valid at clk cycle 168 after acceptance.
REQ-036 ir_only: cmd_ir=2'b10, cmd_ir_only=1, vji_ir_out=2'b11 -> only uir then rti strobes; resp_ir_out=2'b11; resp_data=0; resp_valid at cycle 8.
REQ-037 Reset during SDR bit 10: reset=1 for 1 cycle -> next cycle vji_tck=0, all strobes 0, no resp_valid; a following command completes correctly.
REQ-038 TCK_DIV=1, vji_tdo tied 1 -> resp_data=all ones; vji_tck period 2 clk; tdi changes only on falling edges.
REQ-039 Backpressure: resp_ready=0 for 20 cycles -> resp_valid and resp_data held; cmd_ready=0 throughout; cmd_valid is not accepted until after the resp handshake.
REQ-040 Back-to-back: cmd_valid held high with resp_ready=1 -> second acceptance exactly 2 cycles after the first resp_valid; vji_ir_in changes only at acceptance.

Source files
------------

// File: rtl/cpu_debug_vjtag_host_pkg.sv
// Shared types and constants for the virtual-JTAG debug host.
package cpu_debug_vjtag_host_pkg;

  localparam int VJI_IR_W       = 2;
  localparam int DR_LEN_DEFAULT = 38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cpu_debug_vjtag_host_tckgen.sv
// TCK generator: down-counts clk cycles per half-period and flags the clk
// cycle on which TCK will rise or fall. Held low and reloaded while run=0.
module cpu_debug_vjtag_host_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tck_q, tck_d;
  logic             term;

  always_comb begin
    term      = (div_cnt_q == '0);
    div_cnt_d = div_cnt_q;
    tck_d     = tck_q;
    if (!run) begin
      div_cnt_d = DIV_LOAD;
      tck_d     = 1'b0;
    end else if (term) begin
      div_cnt_d = DIV_LOAD;
      tck_d     = ~tck_q;
    end else begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= DIV_LOAD;
      tck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tck_q     <= tck_d;
    end
  end

  assign tck        = tck_q;
  assign rise_pulse = run && term && !tck_q;
  assign fall_pulse = run && term && tck_q;

endmodule

// File: rtl/cpu_debug_vjtag_host.sv
// Host end of the debug-slave virtual-JTAG link: runs one IR update plus an
// optional DR scan per command and returns the captured TDO and IR readback.
//
// state | meaning
// IDLE  | tck low, cmd_ready high, waiting for a command
// UIR   | one tck period, vji_uir high, slave ir_out captured
// CDR   | one tck period, vji_cdr high
// SDR   | DR_LEN tck periods shifting tdi out / tdo in, LSB first
// UDR   | one tck period, vji_udr high
// RTI   | RTI_TCKS tck periods, vji_rti high
// RESP  | tck low, resp_valid high until resp_ready
module cpu_debug_vjtag_host
  import cpu_debug_vjtag_host_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int DR_LEN   = DR_LEN_DEFAULT,
  parameter int RTI_TCKS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [VJI_IR_W-1:0] cmd_ir,
  input  logic [DR_LEN-1:0]   cmd_dr,
  input  logic                cmd_ir_only,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DR_LEN-1:0]   resp_data,
  output logic [VJI_IR_W-1:0] resp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [VJI_IR_W-1:0] vji_ir_in,
  input  logic [VJI_IR_W-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CNT_MAX = (DR_LEN > RTI_TCKS) ? DR_LEN : RTI_TCKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SDR_LOAD = CNT_W'(DR_LEN - 1);
  localparam logic [CNT_W-1:0] RTI_LOAD = CNT_W'(RTI_TCKS - 1);

  state_e              state_q, state_d;
  logic [VJI_IR_W-1:0] ir_in_q, ir_in_d;
  logic [VJI_IR_W-1:0] ir_out_q, ir_out_d;
  logic                ir_only_q, ir_only_d;
  logic [DR_LEN-1:0]   shift_q, shift_d;
  logic [DR_LEN-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

  logic run, tck, rise_pulse, fall_pulse;

  assign run = (state_q != ST_IDLE) && (state_q != ST_RESP);

  cpu_debug_vjtag_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .tck        (tck),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always_comb begin
    state_d   = state_q;
    ir_in_d   = ir_in_q;
    ir_out_d  = ir_out_q;
    ir_only_d = ir_only_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ir_in_d   = cmd_ir;
          ir_only_d = cmd_ir_only;
          shift_d   = cmd_dr;
          data_d    = '0;
          state_d   = ST_UIR;
        end
      end
      ST_UIR: begin
        if (rise_pulse) ir_out_d = vji_ir_out;
        if (fall_pulse) begin
          if (ir_only_q) begin
            state_d   = ST_RTI;
            bit_cnt_d = RTI_LOAD;
          end else begin
            state_d = ST_CDR;
          end
        end
      end
      ST_CDR: begin
        if (fall_pulse) begin
          state_d   = ST_SDR;
          bit_cnt_d = SDR_LOAD;
        end
      end
      ST_SDR: begin
        // tdo lands in the MSB and walks down, so bit k ends at position k
        if (rise_pulse) begin
          data_d             = data_q >> 1;
          data_d[DR_LEN-1]   = vji_tdo;
        end
        if (fall_pulse) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == '0) state_d = ST_UDR;
          else                 bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ST_UDR: begin
        if (fall_pulse) begin
          state_d   = ST_RTI;
          bit_cnt_d = RTI_LOAD;
        end
      end
      ST_RTI: begin
        if (fall_pulse) begin
          if (bit_cnt_q == '0) state_d = ST_RESP;
          else                 bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_in_q   <= '0;
      ir_out_q  <= '0;
      ir_only_q <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_in_q   <= ir_in_d;
      ir_out_q  <= ir_out_d;
      ir_only_q <= ir_only_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // reset gates ready so every output reads zero while reset is held
  assign cmd_ready   = (state_q == ST_IDLE) && !reset;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = data_q;
  assign resp_ir_out = ir_out_q;
  assign vji_tck     = tck;
  assign vji_tdi     = (state_q == ST_SDR) ? shift_q[0] : 1'b0;
  assign vji_ir_in   = ir_in_q;
  assign vji_uir     = (state_q == ST_UIR);
  assign vji_cdr     = (state_q == ST_CDR);
  assign vji_sdr     = (state_q == ST_SDR);
  assign vji_udr     = (state_q == ST_UDR);
  assign vji_rti     = (state_q == ST_RTI);

endmodule

// File: tb/tb_cpu_debug_vjtag_host.sv
// Self-checking bench: a behavioural slave on instance A, a fast-TCK
// instance B with tdo tied high, and edge-discipline monitors on both.
module tb_cpu_debug_vjtag_host;

  localparam int DRL = 38;
  localparam logic [4:0] S_UIR = 5'b10000;
  localparam logic [4:0] S_CDR = 5'b01000;
  localparam logic [4:0] S_SDR = 5'b00100;
  localparam logic [4:0] S_UDR = 5'b00010;
  localparam logic [4:0] S_RTI = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // instance A (defaults)
  logic           a_cmd_valid, a_cmd_ready, a_cmd_ir_only, a_resp_valid, a_resp_ready;
  logic [1:0]     a_cmd_ir, a_resp_ir_out, a_ir_in, a_ir_out;
  logic [DRL-1:0] a_cmd_dr, a_resp_data;
  logic           a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;
  // instance B (TCK_DIV=1, RTI_TCKS=2)
  logic           b_cmd_valid, b_cmd_ready, b_cmd_ir_only, b_resp_valid, b_resp_ready;
  logic [1:0]     b_cmd_ir, b_resp_ir_out, b_ir_in, b_ir_out;
  logic [DRL-1:0] b_cmd_dr, b_resp_data;
  logic           b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;

  assign b_tdo    = 1'b1;
  assign b_ir_out = 2'b01;

  cpu_debug_vjtag_host #(.TCK_DIV(2), .DR_LEN(DRL), .RTI_TCKS(1)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ir(a_cmd_ir),
    .cmd_dr(a_cmd_dr), .cmd_ir_only(a_cmd_ir_only),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_data(a_resp_data), .resp_ir_out(a_resp_ir_out),
    .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo),
    .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
    .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti)
  );

  cpu_debug_vjtag_host #(.TCK_DIV(1), .DR_LEN(DRL), .RTI_TCKS(2)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir),
    .cmd_dr(b_cmd_dr), .cmd_ir_only(b_cmd_ir_only),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_ir_out(b_resp_ir_out),
    .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
    .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
    .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
  );

  // behavioural slave for A: preloaded TDO, records TDI and strobes per TCK rise
  logic [DRL-1:0] sl_tdo_pre, sl_rx;
  int             sl_idx, sl_rises;
  logic [4:0]     sl_seq[$];

  assign a_tdo = (sl_idx < DRL) ? sl_tdo_pre[sl_idx[5:0]] : 1'b0;

  always @(posedge a_tck) begin
    sl_rises++;
    sl_seq.push_back({a_uir, a_cdr, a_sdr, a_udr, a_rti});
    if (a_sdr) begin
      if (sl_idx < DRL) sl_rx[sl_idx[5:0]] = a_tdi;
      sl_idx++;
    end
  end

  // monitors: driven signals move only on tck fall or acceptance; TCK period
  int         cyc_n = 0;
  logic       prst = 1'b1;
  logic       a_ptck = 1'b0, a_ptdi = 1'b0, a_pacc = 1'b0;
  logic       b_ptck = 1'b0, b_ptdi = 1'b0, b_pacc = 1'b0;
  logic [1:0] a_pir = 2'b00, b_pir = 2'b00;
  logic [4:0] a_pstb = 5'b0, b_pstb = 5'b0;
  int a_viol = 0, b_viol = 0, a_bad_per = 0, b_bad_per = 0;
  int a_last_rise = -1, b_last_rise = -1, a_per_seen = 0, b_per_seen = 0;

  always @(negedge clk) begin
    logic [4:0] a_stb, b_stb;
    a_stb = {a_uir, a_cdr, a_sdr, a_udr, a_rti};
    b_stb = {b_uir, b_cdr, b_sdr, b_udr, b_rti};
    cyc_n++;
    if (!prst) begin
      if ((a_tdi !== a_ptdi || a_stb !== a_pstb) && !(a_ptck && !a_tck) && !a_pacc) a_viol++;
      if (a_ir_in !== a_pir && !a_pacc) a_viol++;
      if ((b_tdi !== b_ptdi || b_stb !== b_pstb) && !(b_ptck && !b_tck) && !b_pacc) b_viol++;
      if (b_ir_in !== b_pir && !b_pacc) b_viol++;
    end
    if (prst || a_stb == 5'b0) a_last_rise = -1;
    else if (a_tck && !a_ptck) begin
      if (a_last_rise >= 0) begin
        a_per_seen++;
        if (cyc_n - a_last_rise != 4) a_bad_per++;
      end
      a_last_rise = cyc_n;
    end
    if (prst || b_stb == 5'b0) b_last_rise = -1;
    else if (b_tck && !b_ptck) begin
      if (b_last_rise >= 0) begin
        b_per_seen++;
        if (cyc_n - b_last_rise != 2) b_bad_per++;
      end
      b_last_rise = cyc_n;
    end
    a_ptck = a_tck; a_ptdi = a_tdi; a_pir = a_ir_in; a_pstb = a_stb;
    b_ptck = b_tck; b_ptdi = b_tdi; b_pir = b_ir_in; b_pstb = b_stb;
    a_pacc = a_cmd_valid && a_cmd_ready;
    b_pacc = b_cmd_valid && b_cmd_ready;
    prst   = reset;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DRL-1:0] rnd_dr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DRL-1:0];
  endfunction

  task automatic slave_clear(input logic [DRL-1:0] tdo_pre);
    sl_tdo_pre = tdo_pre;
    sl_idx     = 0;
    sl_rises   = 0;
    sl_rx      = '0;
    sl_seq.delete();
  endtask

  // issue one command on A and wait for the acceptance edge
  task automatic accept_a(input logic [1:0] ir, input logic [DRL-1:0] dr, input logic ir_only);
    int guard;
    a_cmd_ir = ir; a_cmd_dr = dr; a_cmd_ir_only = ir_only; a_cmd_valid = 1'b1;
    guard = 0;
    while (!a_cmd_ready && guard < 50) begin tick(); guard++; end
    check("a_accept_timeout", 64'(guard < 50), 64'd1);
    tick();
    a_cmd_valid = 1'b0;
    a_cmd_ir = 2'($urandom); a_cmd_dr = rnd_dr(); a_cmd_ir_only = 1'($urandom);
  endtask

  task automatic run_a(input logic [1:0] ir, input logic [DRL-1:0] dr, input logic ir_only,
                       input logic [DRL-1:0] tdo_pre, input logic [1:0] irout, input int bp);
    int lat, seq_err, hold_err, exp_lat, exp_rises;
    logic [4:0] exp_seq[$];
    logic [DRL-1:0] held;
    slave_clear(tdo_pre);
    a_ir_out = irout;
    accept_a(ir, dr, ir_only);
    lat = 0;
    while (!a_resp_valid && lat < 2000) begin tick(); lat++; end
    exp_rises = ir_only ? 2 : DRL + 4;
    exp_lat   = exp_rises * 4;
    check("a_latency", 64'(lat), 64'(exp_lat));
    check("a_resp_data", 64'(a_resp_data), ir_only ? 64'd0 : 64'(tdo_pre));
    check("a_resp_ir_out", 64'(a_resp_ir_out), 64'(irout));
    check("a_ir_in", 64'(a_ir_in), 64'(ir));
    check("a_tck_strobes_in_resp", 64'({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'd0);
    check("a_tck_rises", 64'(sl_rises), 64'(exp_rises));
    check("a_slave_rx", 64'(sl_rx), ir_only ? 64'd0 : 64'(dr));
    exp_seq.push_back(S_UIR);
    if (!ir_only) begin
      exp_seq.push_back(S_CDR);
      for (int i = 0; i < DRL; i++) exp_seq.push_back(S_SDR);
      exp_seq.push_back(S_UDR);
    end
    exp_seq.push_back(S_RTI);
    seq_err = (sl_seq.size() != exp_seq.size()) ? 1 : 0;
    for (int i = 0; i < exp_seq.size() && i < sl_seq.size(); i++)
      if (sl_seq[i] !== exp_seq[i]) seq_err++;
    check("a_strobe_sequence", 64'(seq_err), 64'd0);
    if (bp > 0) begin
      held = a_resp_data;
      hold_err = 0;
      a_cmd_valid = 1'b1; a_cmd_ir = ~ir; a_cmd_dr = rnd_dr();
      repeat (bp) begin
        tick();
        if (!a_resp_valid || a_resp_data !== held || a_cmd_ready || a_ir_in !== ir) hold_err++;
      end
      a_cmd_valid = 1'b0;
      check("a_backpressure_hold", 64'(hold_err), 64'd0);
    end
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    check("a_resp_handshake", 64'({a_resp_valid, a_cmd_ready}), 64'b01);
  endtask

  task automatic run_b(input logic [DRL-1:0] dr);
    int guard, lat;
    b_cmd_ir = 2'($urandom); b_cmd_dr = dr; b_cmd_ir_only = 1'b0; b_cmd_valid = 1'b1;
    guard = 0;
    while (!b_cmd_ready && guard < 50) begin tick(); guard++; end
    tick();
    b_cmd_valid = 1'b0;
    lat = 0;
    while (!b_resp_valid && lat < 2000) begin tick(); lat++; end
    check("b_latency", 64'(lat), 64'((DRL + 3 + 2) * 2));
    check("b_resp_data", 64'(b_resp_data), 64'({DRL{1'b1}}));
    check("b_resp_ir_out", 64'(b_resp_ir_out), 64'd1);
    b_resp_ready = 1'b1;
    tick();
    b_resp_ready = 1'b0;
  endtask

  initial begin
    int guard, first_resp, n_acc, acc_cyc, cyc, ir_err, rv_err;
    logic acc_next;
    logic [1:0] ir_sample;

    reset = 1'b1;
    a_cmd_valid = 0; a_cmd_ir = 0; a_cmd_dr = '0; a_cmd_ir_only = 0; a_resp_ready = 0; a_ir_out = 0;
    b_cmd_valid = 0; b_cmd_ir = 0; b_cmd_dr = '0; b_cmd_ir_only = 0; b_resp_ready = 0;
    slave_clear('0);
    repeat (3) tick();
    check("reset_outputs_a", 64'({a_cmd_ready, a_resp_valid, a_tck, a_tdi, a_ir_in, a_resp_ir_out,
                                  a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'd0);
    check("reset_resp_data_a", 64'(a_resp_data), 64'd0);
    check("reset_outputs_b", 64'({b_cmd_ready, b_resp_valid, b_tck}), 64'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", 64'({a_cmd_ready, b_cmd_ready}), 64'b11);

    run_a(2'b01, 38'h2A_5A5A_5A5A, 1'b0, 38'h12_3456_789A, 2'b00, 0);
    run_a(2'b10, rnd_dr(), 1'b1, rnd_dr(), 2'b11, 0);
    run_a(2'($urandom), rnd_dr(), 1'b0, rnd_dr(), 2'($urandom), 20);
    for (int i = 0; i < 5; i++)
      run_a(2'($urandom), rnd_dr(), 1'($urandom), rnd_dr(), 2'($urandom), int'($urandom_range(0, 3)));

    // reset in the middle of SDR bit 10
    slave_clear(rnd_dr());
    accept_a(2'b11, rnd_dr(), 1'b0);
    guard = 0;
    while (sl_idx < 10 && guard < 500) begin tick(); guard++; end
    check("reach_sdr_bit10", 64'({a_sdr, 1'(sl_idx == 10)}), 64'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_outputs", 64'({a_tck, a_tdi, a_resp_valid, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'd0);
    rv_err = 0;
    repeat (10) begin tick(); if (a_resp_valid || a_tck) rv_err++; end
    check("abort_no_resp", 64'(rv_err), 64'd0);
    check("abort_ready", 64'(a_cmd_ready), 64'd1);
    run_a(2'b01, rnd_dr(), 1'b0, rnd_dr(), 2'b10, 0);

    // back-to-back ir_only commands with valid and ready held high
    slave_clear('0);
    a_ir_out = 2'($urandom);
    a_cmd_ir_only = 1'b1; a_cmd_valid = 1'b1; a_resp_ready = 1'b1;
    first_resp = -1; n_acc = 0; acc_cyc = -1; cyc = 0; ir_err = 0;
    while (n_acc < 2 && cyc < 200) begin
      a_cmd_ir  = 2'($urandom);
      ir_sample = a_cmd_ir;
      acc_next  = a_cmd_valid && a_cmd_ready;
      tick();
      cyc++;
      if (acc_next) begin
        n_acc++;
        acc_cyc = cyc;
        if (a_ir_in !== ir_sample) ir_err++;
      end
      if (a_resp_valid && first_resp < 0) first_resp = cyc;
    end
    a_cmd_valid = 1'b0;
    check("b2b_second_accept", 64'(acc_cyc - first_resp), 64'd2);
    check("b2b_ir_in_at_accept", 64'(ir_err), 64'd0);
    guard = 0;
    while (!a_cmd_ready && guard < 100) begin tick(); guard++; end
    check("b2b_drain", 64'(guard < 100), 64'd1);
    a_resp_ready = 1'b0;

    for (int i = 0; i < 3; i++) run_b(rnd_dr());

    repeat (5) tick();
    check("a_drive_edge_violations", 64'(a_viol), 64'd0);
    check("b_drive_edge_violations", 64'(b_viol), 64'd0);
    check("a_tck_period_errors", 64'(a_bad_per), 64'd0);
    check("b_tck_period_errors", 64'(b_bad_per), 64'd0);
    check("periods_observed", 64'({1'(a_per_seen > 100), 1'(b_per_seen > 100)}), 64'b11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
